// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : Bundle of EX/MEM inputs, MEM/WB outputs and the debug read
//               port of the memory-access stage.
//   slave  : used by mem_stage (consumes EX/MEM fields, drives MEM/WB fields)
//   master : used by the producer/observer side (pipeline or testbench)
//   Signals: i_step, i_mem2reg, i_memWrite, i_regWrite, i_width, i_sign_flag,
//            i_write_reg, i_result, i_data4Mem, i_debug_addr (into stage)
//            o_mem2reg, o_regWrite, o_write_reg, o_mem_data, o_alu_result,
//            o_misaligned, o_debug_data (out of stage)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5
);
  logic               i_step;
  logic               i_mem2reg;
  logic               i_memWrite;
  logic               i_regWrite;
  logic [1:0]         i_width;
  logic               i_sign_flag;
  logic [NB_REG-1:0]  i_write_reg;
  logic [NB_DATA-1:0] i_result;
  logic [NB_DATA-1:0] i_data4Mem;
  logic [NB_ADDR-1:0] i_debug_addr;
  logic               o_mem2reg;
  logic               o_regWrite;
  logic [NB_REG-1:0]  o_write_reg;
  logic [NB_DATA-1:0] o_mem_data;
  logic [NB_DATA-1:0] o_alu_result;
  logic               o_misaligned;
  logic [NB_DATA-1:0] o_debug_data;

  modport slave (
    input  i_step, i_mem2reg, i_memWrite, i_regWrite, i_width, i_sign_flag,
           i_write_reg, i_result, i_data4Mem, i_debug_addr,
    output o_mem2reg, o_regWrite, o_write_reg, o_mem_data, o_alu_result,
           o_misaligned, o_debug_data
  );

  modport master (
    output i_step, i_mem2reg, i_memWrite, i_regWrite, i_width, i_sign_flag,
           i_write_reg, i_result, i_data4Mem, i_debug_addr,
    input  o_mem2reg, o_regWrite, o_write_reg, o_mem_data, o_alu_result,
           o_misaligned, o_debug_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : DLX/MIPS memory-access stage. Byte/half/word loads and stores
//               into an internal little-endian data memory, sign/zero
//               extension of load data, MEM/WB pipeline register, sticky
//               misaligned-access flag and a combinational debug read port.
//   clk     : rising-edge clock
//   i_reset : asynchronous active-high reset (clears registers and memory)
//   bus     : mem_stage_if.slave (EX/MEM inputs, MEM/WB outputs, debug port)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5
) (
  input  wire logic   clk,
  input  wire logic   i_reset,
  mem_stage_if.slave  bus
);

  localparam int C_DEPTH = 2 ** NB_ADDR;
  localparam int C_LANES = NB_DATA / 8;

  logic [NB_DATA-1:0] mem [C_DEPTH];

  logic [NB_ADDR-1:0] w_word_idx;
  logic [1:0]         w_off;
  logic               w_addr_misaligned;
  logic               w_acc_misaligned;
  logic [NB_DATA-1:0] w_rd_word;
  logic [7:0]         w_rd_byte;
  logic [15:0]        w_rd_half;
  logic [NB_DATA-1:0] w_load_data;
  logic [NB_DATA-1:0] w_wr_data;
  logic [C_LANES-1:0] w_wr_en;

  // Upper address bits are simply dropped, so accesses wrap modulo memory size.
  assign w_word_idx = bus.i_result[NB_ADDR+1:2];
  assign w_off      = bus.i_result[1:0];

  always_comb begin
    w_addr_misaligned = 1'b0;
    case (bus.i_width)
      2'b00:   w_addr_misaligned = 1'b0;
      2'b01:   w_addr_misaligned = w_off[0];
      default: w_addr_misaligned = (w_off != 2'b00);
    endcase
  end

  assign w_acc_misaligned = w_addr_misaligned & (bus.i_memWrite | bus.i_mem2reg);

  // Load path: combinational read of the current word, then lane select/extend.
  assign w_rd_word = mem[w_word_idx];

  always_comb begin
    w_rd_byte = w_rd_word[7:0];
    case (w_off)
      2'd0: w_rd_byte = w_rd_word[7:0];
      2'd1: w_rd_byte = w_rd_word[15:8];
      2'd2: w_rd_byte = w_rd_word[23:16];
      2'd3: w_rd_byte = w_rd_word[31:24];
      default: w_rd_byte = w_rd_word[7:0];
    endcase
    w_rd_half = w_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];
  end

  always_comb begin
    w_load_data = w_rd_word;
    case (bus.i_width)
      2'b00: w_load_data = {{(NB_DATA-8){bus.i_sign_flag & w_rd_byte[7]}}, w_rd_byte};
      2'b01: w_load_data = {{(NB_DATA-16){bus.i_sign_flag & w_rd_half[15]}}, w_rd_half};
      default: w_load_data = w_rd_word;
    endcase
    if (w_addr_misaligned) begin
      w_load_data = '0;
    end
  end

  // Store path: replicate the source across lanes and enable only the target lanes.
  always_comb begin
    w_wr_data = bus.i_data4Mem;
    w_wr_en   = '1;
    case (bus.i_width)
      2'b00: begin
        w_wr_data = {C_LANES{bus.i_data4Mem[7:0]}};
        w_wr_en   = C_LANES'(1) << w_off;
      end
      2'b01: begin
        w_wr_data = {(C_LANES/2){bus.i_data4Mem[15:0]}};
        w_wr_en   = w_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wr_data = bus.i_data4Mem;
        w_wr_en   = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      for (int w = 0; w < C_DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (bus.i_step && bus.i_memWrite && !w_addr_misaligned) begin
      for (int l = 0; l < C_LANES; l++) begin
        if (w_wr_en[l]) begin
          mem[w_word_idx][l*8 +: 8] <= w_wr_data[l*8 +: 8];
        end
      end
    end
  end

  // MEM/WB pipeline register and sticky misaligned flag.
  logic               r_mem2reg;
  logic               r_regWrite;
  logic [NB_REG-1:0]  r_write_reg;
  logic [NB_DATA-1:0] r_mem_data;
  logic [NB_DATA-1:0] r_alu_result;
  logic               r_misaligned;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem2reg    <= 1'b0;
      r_regWrite   <= 1'b0;
      r_write_reg  <= '0;
      r_mem_data   <= '0;
      r_alu_result <= '0;
      r_misaligned <= 1'b0;
    end else if (bus.i_step) begin
      r_mem2reg    <= bus.i_mem2reg;
      r_regWrite   <= bus.i_regWrite;
      r_write_reg  <= bus.i_write_reg;
      r_mem_data   <= w_load_data;
      r_alu_result <= bus.i_result;
      if (w_acc_misaligned) begin
        r_misaligned <= 1'b1;
      end
    end
  end

  assign bus.o_mem2reg    = r_mem2reg;
  assign bus.o_regWrite   = r_regWrite;
  assign bus.o_write_reg  = r_write_reg;
  assign bus.o_mem_data   = r_mem_data;
  assign bus.o_alu_result = r_alu_result;
  assign bus.o_misaligned = r_misaligned;
  assign bus.o_debug_data = mem[bus.i_debug_addr];

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage. Stimulus pushes expected
//               MEM/WB contents into a queue; a monitor pops and compares
//               after every step edge. Reference is a byte-addressed memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic clk = 1'b0;
  logic i_reset = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if #(.NB_DATA(32), .NB_ADDR(8), .NB_REG(5)) bus ();

  mem_stage #(.NB_DATA(32), .NB_ADDR(8), .NB_REG(5)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  typedef struct packed {
    logic        mem2reg;
    logic        regwrite;
    logic [4:0]  wreg;
    logic [31:0] mdata;
    logic [31:0] alu;
    logic        flag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_exp;
  logic [7:0]  mb [1024];
  logic        flag_m;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  function automatic logic misal(input logic [1:0] width, input int a);
    if (width == 2'b00) return 1'b0;
    if (width == 2'b01) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] width, input logic sgn, input int a);
    logic [31:0] v;
    if (misal(width, a)) return 32'h0;
    if (width == 2'b00) begin
      v = {24'h0, mb[a]};
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (width == 2'b01) begin
      v = {16'h0, mb[a+1], mb[a]};
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = mword(a / 4);
    end
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) mb[i] = 8'h0;
    flag_m   = 1'b0;
    last_exp = '0;
  endtask

  // One stepped transaction: presented at negedge, captured at next posedge.
  task automatic issue(input logic wr, input logic rd, input logic rw, input logic [1:0] width,
                       input logic sgn, input logic [4:0] wreg, input logic [31:0] res,
                       input logic [31:0] data);
    int   a;
    logic m;
    exp_t e;
    @(negedge clk);
    bus.i_memWrite  = wr;
    bus.i_mem2reg   = rd;
    bus.i_regWrite  = rw;
    bus.i_width     = width;
    bus.i_sign_flag = sgn;
    bus.i_write_reg = wreg;
    bus.i_result    = res;
    bus.i_data4Mem  = data;
    bus.i_step      = 1'b1;
    a = int'(res & 32'h3FF);
    m = (wr | rd) & misal(width, a);
    if (m) flag_m = 1'b1;
    e.mem2reg  = rd;
    e.regwrite = rw;
    e.wreg     = wreg;
    e.mdata    = model_load(width, sgn, a);
    e.alu      = res;
    e.flag     = flag_m;
    sb_q.push_back(e);
    last_exp = e;
    if (wr && !m) begin
      if (width == 2'b00) mb[a] = data[7:0];
      else if (width == 2'b01) begin
        mb[a] = data[7:0]; mb[a+1] = data[15:8];
      end else begin
        for (int k = 0; k < 4; k++) mb[a+k] = 8'((data >> (8*k)) & 32'hFF);
      end
    end
    @(posedge clk);
    #2;
    bus.i_step = 1'b0;
  endtask

  task automatic dbg(input int w, input logic [31:0] exp, input string name);
    bus.i_debug_addr = w[7:0];
    #1;
    chk(name, bus.o_debug_data, exp);
  endtask

  // Monitor: pops one expectation per step edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.i_step && !i_reset) begin
        #1;
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("mem2reg",   {31'h0, bus.o_mem2reg},  {31'h0, e.mem2reg});
          chk("regWrite",  {31'h0, bus.o_regWrite}, {31'h0, e.regwrite});
          chk("write_reg", {27'h0, bus.o_write_reg}, {27'h0, e.wreg});
          chk("alu_result", bus.o_alu_result, e.alu);
          chk("misaligned", {31'h0, bus.o_misaligned}, {31'h0, e.flag});
          if (e.mem2reg) chk("mem_data", bus.o_mem_data, e.mdata);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic [1:0]  w;
    bus.i_step = 0; bus.i_memWrite = 0; bus.i_mem2reg = 0; bus.i_regWrite = 0;
    bus.i_width = 2'b10; bus.i_sign_flag = 0; bus.i_write_reg = 0;
    bus.i_result = 0; bus.i_data4Mem = 0; bus.i_debug_addr = 0;
    clear_model();
    #12;
    chk("rst_mem_data", bus.o_mem_data, 32'h0);
    chk("rst_alu", bus.o_alu_result, 32'h0);
    chk("rst_flag", {31'h0, bus.o_misaligned}, 32'h0);
    i_reset = 1'b0;

    // Word round trip
    issue(1, 0, 0, 2'b10, 0, 5'd0, 32'h10, 32'hDEADBEEF);
    issue(0, 1, 1, 2'b10, 0, 5'd5, 32'h10, 32'h0);
    chk("lw_data", bus.o_mem_data, 32'hDEADBEEF);
    chk("lw_wreg", {27'h0, bus.o_write_reg}, 32'd5);
    dbg(4, 32'hDEADBEEF, "dbg_word4");

    // Byte lanes
    issue(1, 0, 0, 2'b00, 0, 5'd0, 32'h21, 32'h80);
    issue(1, 0, 0, 2'b00, 0, 5'd0, 32'h22, 32'h7F);
    dbg(8, 32'h007F8000, "dbg_word8");
    issue(0, 1, 1, 2'b00, 1, 5'd1, 32'h21, 32'h0);
    chk("lb_s", bus.o_mem_data, 32'hFFFFFF80);
    issue(0, 1, 1, 2'b00, 0, 5'd1, 32'h21, 32'h0);
    chk("lbu", bus.o_mem_data, 32'h00000080);
    issue(0, 1, 1, 2'b00, 1, 5'd1, 32'h22, 32'h0);
    chk("lb_pos", bus.o_mem_data, 32'h0000007F);

    // Halfword
    issue(1, 0, 0, 2'b10, 0, 5'd0, 32'h30, 32'h11223344);
    issue(1, 0, 0, 2'b01, 0, 5'd0, 32'h32, 32'h00008001);
    dbg(12, 32'h80013344, "dbg_word12");
    issue(0, 1, 1, 2'b01, 1, 5'd2, 32'h32, 32'h0);
    chk("lh_s", bus.o_mem_data, 32'hFFFF8001);
    issue(0, 1, 1, 2'b01, 0, 5'd2, 32'h30, 32'h0);
    chk("lhu", bus.o_mem_data, 32'h00003344);

    // Step hold: store presented with step low must do nothing.
    @(negedge clk);
    bus.i_memWrite = 1; bus.i_mem2reg = 0; bus.i_width = 2'b10;
    bus.i_result = 32'h08; bus.i_data4Mem = 32'h12345678; bus.i_write_reg = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_alu", bus.o_alu_result, last_exp.alu);
    chk("hold_wreg", {27'h0, bus.o_write_reg}, {27'h0, last_exp.wreg});
    dbg(2, 32'h0, "hold_mem");
    // Wrap: 0x408 lands in word 2
    issue(1, 0, 0, 2'b10, 0, 5'd0, 32'h408, 32'hCAFEF00D);
    dbg(2, 32'hCAFEF00D, "wrap_word2");

    // Misaligned store suppressed, flag sticky
    issue(1, 0, 0, 2'b10, 0, 5'd0, 32'h41, 32'hFFFFFFFF);
    dbg(16, 32'h0, "mis_mem");
    chk("mis_flag", {31'h0, bus.o_misaligned}, 32'd1);
    issue(0, 1, 1, 2'b01, 1, 5'd3, 32'h43, 32'h0);
    chk("mis_lh", bus.o_mem_data, 32'h0);
    issue(0, 1, 1, 2'b10, 0, 5'd3, 32'h10, 32'h0);
    chk("mis_sticky", {31'h0, bus.o_misaligned}, 32'd1);

    // Randomized traffic in a 64-byte window with random upper (ignored) bits
    for (int i = 0; i < 300; i++) begin
      w   = 2'($urandom_range(0, 3));
      res = $urandom & ~32'h3C0;
      if ($urandom_range(0, 3) != 0) begin
        if (w == 2'b01) res[0] = 1'b0;
        else if (w[1]) res[1:0] = 2'b00;
      end
      issue(1'($urandom), 1'($urandom), 1'($urandom), w, 1'($urandom),
            5'($urandom), res, $urandom);
      if (i % 8 == 0) begin
        int dw;
        dw = $urandom_range(0, 15);
        dbg(dw, mword(dw), "rand_dbg");
      end
    end

    // Asynchronous reset between edges after stores
    issue(1, 0, 1, 2'b10, 0, 5'd7, 32'h14, 32'hA5A5A5A5);
    #1;
    i_reset = 1'b1;
    #1;
    chk("arst_mem_data", bus.o_mem_data, 32'h0);
    chk("arst_alu", bus.o_alu_result, 32'h0);
    chk("arst_regWrite", {31'h0, bus.o_regWrite}, 32'h0);
    chk("arst_flag", {31'h0, bus.o_misaligned}, 32'h0);
    dbg(5, 32'h0, "arst_dbg5");
    dbg(4, 32'h0, "arst_dbg4");
    clear_model();
    bus.i_memWrite = 1; bus.i_width = 2'b10; bus.i_result = 32'h18;
    bus.i_data4Mem = 32'h55AA55AA; bus.i_step = 1;
    @(posedge clk);
    #2;
    bus.i_step = 0;
    i_reset = 1'b0;
    dbg(6, 32'h0, "rst_edge_store");
    issue(0, 1, 1, 2'b10, 0, 5'd4, 32'h18, 32'h0);
    chk("post_rst_load", bus.o_mem_data, 32'h0);

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) chk("sb_drain", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
